// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one memory port between an instruction-fetch requester (read only)
// and a load/store requester. Load/store normally wins. A saturating starvation
// counter hands the port to fetch after STARVE_MAX back-to-back load/store
// grants taken while fetch was waiting.
//
// One access is in flight at a time:
//   grant (T) -> mem_req with latched fields (T+1 ..) -> owner rvalid the cycle
//   after mem_ready. No new grant while either rvalid is high, so grants are at
//   least 3 cycles apart.
//
// Ports
//   clk, reset                 clock, asynchronous active-low reset
//   if_req/if_addr             fetch request
//   if_gnt/if_rvalid/if_rdata  fetch grant, completion pulse, read data
//   ls_req/ls_we/ls_be/
//   ls_addr/ls_wdata           load/store request
//   ls_gnt/ls_rvalid/ls_rdata  load/store grant, completion pulse, load data
//                              (stores complete with ls_rdata = 0)
//   mem_req/mem_we/mem_be/
//   mem_addr/mem_wdata         shared memory port, driven only while busy
//   mem_rdata/mem_ready        memory read data and access-complete strobe
//   stall_if/stall_mem         stall requests for the IF and MEM stages
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,

    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [3:0]  ls_be,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_gnt,
    output logic        ls_rvalid,
    output logic [31:0] ls_rdata,

    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,

    output logic        stall_if,
    output logic        stall_mem
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] BUSY_IF = 2'd1;
    localparam logic [1:0] BUSY_LS = 2'd2;

    localparam int unsigned CntW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CntW-1:0] StarveMax = CntW'(STARVE_MAX);

    logic [1:0]      state_q, state_d;
    logic [CntW-1:0] starve_cnt_q, starve_cnt_d;
    logic [31:0]     addr_q, addr_d;
    logic            we_q, we_d;
    logic [3:0]      be_q, be_d;
    logic [31:0]     wdata_q, wdata_d;
    logic            if_rvalid_q, if_rvalid_d;
    logic            ls_rvalid_q, ls_rvalid_d;
    logic [31:0]     if_rdata_q, if_rdata_d;
    logic [31:0]     ls_rdata_q, ls_rdata_d;

    logic grant_ok;
    logic fetch_wins;
    logic if_gnt_w;
    logic ls_gnt_w;
    logic busy;

    // Grants are combinational; reset gates them so every output is 0 while
    // reset is held, even with requests present.
    always_comb begin
        grant_ok   = reset && (state_q == IDLE) && !if_rvalid_q && !ls_rvalid_q;
        fetch_wins = !ls_req || (starve_cnt_q == StarveMax);
        if_gnt_w   = grant_ok && if_req && fetch_wins;
        ls_gnt_w   = grant_ok && ls_req && !if_gnt_w;
    end

    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        addr_d       = addr_q;
        we_d         = we_q;
        be_d         = be_q;
        wdata_d      = wdata_q;
        if_rdata_d   = if_rdata_q;
        ls_rdata_d   = ls_rdata_q;
        if_rvalid_d  = 1'b0;
        ls_rvalid_d  = 1'b0;

        case (state_q)
            IDLE: begin
                // mem_ready is ignored here.
                if (if_gnt_w) begin
                    state_d = BUSY_IF;
                    addr_d  = if_addr;
                    we_d    = 1'b0;
                    be_d    = 4'hF;
                    wdata_d = 32'h0;
                end else if (ls_gnt_w) begin
                    state_d = BUSY_LS;
                    addr_d  = ls_addr;
                    we_d    = ls_we;
                    be_d    = ls_be;
                    wdata_d = ls_wdata;
                end
            end
            BUSY_IF: begin
                if (mem_ready) begin
                    state_d     = IDLE;
                    if_rdata_d  = mem_rdata;
                    if_rvalid_d = 1'b1;
                end
            end
            BUSY_LS: begin
                if (mem_ready) begin
                    state_d     = IDLE;
                    // A store completes as a pure acknowledge with zero data.
                    ls_rdata_d  = we_q ? 32'h0 : mem_rdata;
                    ls_rvalid_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Counts load/store grants taken while fetch waits; saturates.
        if (!if_req || if_gnt_w) begin
            starve_cnt_d = '0;
        end else if (ls_gnt_w && (starve_cnt_q != StarveMax)) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            starve_cnt_q <= '0;
            addr_q       <= 32'h0;
            we_q         <= 1'b0;
            be_q         <= 4'h0;
            wdata_q      <= 32'h0;
            if_rvalid_q  <= 1'b0;
            ls_rvalid_q  <= 1'b0;
            if_rdata_q   <= 32'h0;
            ls_rdata_q   <= 32'h0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            be_q         <= be_d;
            wdata_q      <= wdata_d;
            if_rvalid_q  <= if_rvalid_d;
            ls_rvalid_q  <= ls_rvalid_d;
            if_rdata_q   <= if_rdata_d;
            ls_rdata_q   <= ls_rdata_d;
        end
    end

    always_comb begin
        busy      = (state_q == BUSY_IF) || (state_q == BUSY_LS);
        if_gnt    = if_gnt_w;
        ls_gnt    = ls_gnt_w;
        if_rvalid = if_rvalid_q;
        ls_rvalid = ls_rvalid_q;
        if_rdata  = if_rdata_q;
        ls_rdata  = ls_rdata_q;
        mem_req   = busy;
        mem_we    = busy & we_q;
        mem_be    = busy ? be_q : 4'h0;
        mem_addr  = busy ? addr_q : 32'h0;
        mem_wdata = busy ? wdata_q : 32'h0;
        stall_if  = reset & if_req & ~if_rvalid_q;
        stall_mem = reset & ls_req & ~ls_rvalid_q;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'h0;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        ls_req = 1'b0;
    logic        ls_we = 1'b0;
    logic [3:0]  ls_be = 4'h0;
    logic [31:0] ls_addr = 32'h0;
    logic [31:0] ls_wdata = 32'h0;
    logic        ls_gnt, ls_rvalid;
    logic [31:0] ls_rdata;
    logic        mem_req, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_ready = 1'b0;
    logic        stall_if, stall_mem;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.STARVE_MAX(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .ls_req    (ls_req),
        .ls_we     (ls_we),
        .ls_be     (ls_be),
        .ls_addr   (ls_addr),
        .ls_wdata  (ls_wdata),
        .ls_gnt    (ls_gnt),
        .ls_rvalid (ls_rvalid),
        .ls_rdata  (ls_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_be    (mem_be),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .stall_if  (stall_if),
        .stall_mem (stall_mem)
    );

    typedef struct {
        string        tag;
        logic         rst;
        logic         if_req;
        logic [31:0]  if_addr;
        logic         ls_req;
        logic         ls_we;
        logic [3:0]   ls_be;
        logic [31:0]  ls_addr;
        logic [31:0]  ls_wdata;
        logic         mem_ready;
        logic [31:0]  mem_rdata;
        logic [139:0] exp;
    } vec_t;

    vec_t vecs[$];

    // Expected output bundle, same field order as act_bundle().
    function automatic logic [139:0] ex(
        input logic ig, input logic lg, input logic irv, input logic lrv,
        input logic sti, input logic stm, input logic mreq, input logic mwe,
        input logic [3:0] mbe, input logic [31:0] maddr, input logic [31:0] mwdata,
        input logic [31:0] ird, input logic [31:0] lrd);
        return {ig, lg, irv, lrv, sti, stm, mreq, mwe, mbe, maddr, mwdata, ird, lrd};
    endfunction

    function automatic logic [139:0] act_bundle();
        return {if_gnt, ls_gnt, if_rvalid, ls_rvalid, stall_if, stall_mem, mem_req, mem_we,
                mem_be, mem_addr, mem_wdata, if_rdata, ls_rdata};
    endfunction

    task automatic add(
        input string tag, input logic rst, input logic ir, input logic [31:0] ia,
        input logic lr, input logic lw, input logic [3:0] lb, input logic [31:0] la,
        input logic [31:0] lwd, input logic mr, input logic [31:0] mrd,
        input logic [139:0] e);
        vec_t v;
        v.tag = tag; v.rst = rst; v.if_req = ir; v.if_addr = ia; v.ls_req = lr;
        v.ls_we = lw; v.ls_be = lb; v.ls_addr = la; v.ls_wdata = lwd;
        v.mem_ready = mr; v.mem_rdata = mrd; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [139:0] act, input logic [139:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          ngr;
        int          cyc;
        int          last;
        int          min_gap;
        logic        both_hi;
        logic        seen;
        logic [9:0]  who;

        // ---------------- table: reset, fetch, store+fetch, byte load -------
        add("rst_hold",   0, 1, 32'h10, 1, 1, 4'hF, 32'h100, 32'h1, 1, 32'h0,
            ex(0,0,0,0,0,0,0,0,4'h0,32'h0,32'h0,32'h0,32'h0));
        add("if_gnt",     1, 1, 32'h10, 0, 0, 4'h0, 32'h0, 32'h0, 0, 32'h0,
            ex(1,0,0,0,1,0,0,0,4'h0,32'h0,32'h0,32'h0,32'h0));
        add("if_busy",    1, 1, 32'h10, 0, 0, 4'h0, 32'h0, 32'h0, 1, 32'h12345037,
            ex(0,0,0,0,1,0,1,0,4'hF,32'h10,32'h0,32'h0,32'h0));
        add("if_rvalid",  1, 1, 32'h10, 0, 0, 4'h0, 32'h0, 32'h0, 0, 32'h0,
            ex(0,0,1,0,0,0,0,0,4'h0,32'h0,32'h0,32'h12345037,32'h0));
        add("idle",       1, 0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 32'h0,
            ex(0,0,0,0,0,0,0,0,4'h0,32'h0,32'h0,32'h12345037,32'h0));
        add("both_ls_win", 1, 1, 32'h20, 1, 1, 4'hF, 32'h100, 32'h123457FF, 0, 32'h0,
            ex(0,1,0,0,1,1,0,0,4'h0,32'h0,32'h0,32'h12345037,32'h0));
        add("st_busy",    1, 1, 32'h20, 1, 1, 4'hF, 32'h100, 32'h123457FF, 1, 32'hDEADBEEF,
            ex(0,0,0,0,1,1,1,1,4'hF,32'h100,32'h123457FF,32'h12345037,32'h0));
        add("st_ack",     1, 1, 32'h20, 1, 1, 4'hF, 32'h100, 32'h123457FF, 0, 32'h0,
            ex(0,0,0,1,1,0,0,0,4'h0,32'h0,32'h0,32'h12345037,32'h0));
        add("if_after_st", 1, 1, 32'h20, 0, 0, 4'h0, 32'h0, 32'h0, 0, 32'h0,
            ex(1,0,0,0,1,0,0,0,4'h0,32'h0,32'h0,32'h12345037,32'h0));
        add("if2_busy",   1, 1, 32'h20, 0, 0, 4'h0, 32'h0, 32'h0, 1, 32'hCAFEF00D,
            ex(0,0,0,0,1,0,1,0,4'hF,32'h20,32'h0,32'h12345037,32'h0));
        add("if2_rvalid", 1, 0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 32'h0,
            ex(0,0,1,0,0,0,0,0,4'h0,32'h0,32'h0,32'hCAFEF00D,32'h0));
        add("byte_gnt",   1, 0, 32'h0, 1, 0, 4'b0010, 32'h101, 32'h0, 0, 32'h0,
            ex(0,1,0,0,0,1,0,0,4'h0,32'h0,32'h0,32'hCAFEF00D,32'h0));
        add("byte_busy",  1, 0, 32'h0, 1, 0, 4'b0010, 32'h101, 32'h0, 1, 32'hFFFF58FF,
            ex(0,0,0,0,0,1,1,0,4'b0010,32'h101,32'h0,32'hCAFEF00D,32'h0));
        add("byte_rvalid", 1, 0, 32'h0, 1, 0, 4'b0010, 32'h101, 32'h0, 0, 32'h0,
            ex(0,0,0,1,0,0,0,0,4'h0,32'h0,32'h0,32'hCAFEF00D,32'hFFFF58FF));
        add("idle_ready", 1, 0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 1, 32'h77,
            ex(0,0,0,0,0,0,0,0,4'h0,32'h0,32'h0,32'hCAFEF00D,32'hFFFF58FF));
        add("idle_quiet", 1, 0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 32'h0,
            ex(0,0,0,0,0,0,0,0,4'h0,32'h0,32'h0,32'hCAFEF00D,32'hFFFF58FF));

        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            reset     = vecs[i].rst;
            if_req    = vecs[i].if_req;
            if_addr   = vecs[i].if_addr;
            ls_req    = vecs[i].ls_req;
            ls_we     = vecs[i].ls_we;
            ls_be     = vecs[i].ls_be;
            ls_addr   = vecs[i].ls_addr;
            ls_wdata  = vecs[i].ls_wdata;
            mem_ready = vecs[i].mem_ready;
            mem_rdata = vecs[i].mem_rdata;
            @(negedge clk);
            chk(vecs[i].tag, act_bundle(), vecs[i].exp);
        end

        // ---------------- starvation: both requesting continuously ----------
        @(posedge clk);
        #1;
        if_req = 1'b1; if_addr = 32'h400;
        ls_req = 1'b1; ls_we = 1'b0; ls_be = 4'hF; ls_addr = 32'h500; ls_wdata = 32'h0;
        mem_ready = 1'b1; mem_rdata = 32'h1;
        ngr = 0; cyc = 0; last = -1; min_gap = 1000; both_hi = 1'b0; who = '0;
        while (ngr < 10 && cyc < 100) begin
            @(negedge clk);
            if (if_gnt && ls_gnt) both_hi = 1'b1;
            if (if_gnt || ls_gnt) begin
                who[ngr] = if_gnt;
                if (last >= 0 && (cyc - last) < min_gap) min_gap = cyc - last;
                last = cyc;
                ngr++;
            end
            cyc++;
        end
        chk("starve_budget", 140'(ngr), 140'(10));
        chk("starve_order", 140'(who), 140'(10'b10000_10000));
        chk("grant_spacing", 140'(min_gap), 140'(3));
        chk("no_double_grant", 140'(both_hi), 140'(0));
        @(posedge clk);
        #1;
        if_req = 1'b0; ls_req = 1'b0;
        repeat (3) @(posedge clk);

        // ---------------- long wait in BUSY_LS -------------------------------
        #1;
        mem_ready = 1'b0;
        ls_req = 1'b1; ls_we = 1'b0; ls_be = 4'b1100; ls_addr = 32'h200; ls_wdata = 32'h55;
        @(negedge clk);
        chk("wait_gnt", 140'({ls_gnt, if_gnt}), 140'(2'b10));
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            mem_rdata = 32'hBAD0_0000 + 32'(i);
            @(negedge clk);
            chk("wait_hold",
                140'({mem_req, mem_we, mem_be, mem_addr, mem_wdata, stall_mem, ls_rvalid}),
                140'({1'b1, 1'b0, 4'b1100, 32'h200, 32'h55, 1'b1, 1'b0}));
        end
        @(posedge clk);
        #1;
        mem_ready = 1'b1; mem_rdata = 32'hA5A50001;
        @(negedge clk);
        chk("wait_ready_cycle", 140'({mem_req, ls_rvalid, stall_mem}), 140'(3'b101));
        @(posedge clk);
        #1;
        mem_ready = 1'b0;
        @(negedge clk);
        chk("wait_rvalid", 140'({ls_rvalid, ls_rdata, stall_mem}),
            140'({1'b1, 32'hA5A50001, 1'b0}));
        @(posedge clk);
        #1;
        ls_req = 1'b0;
        @(negedge clk);
        chk("wait_pulse_end", 140'({ls_rvalid, mem_req}), 140'(2'b00));

        // ---------------- reset during BUSY_IF -------------------------------
        @(posedge clk);
        #1;
        if_req = 1'b1; if_addr = 32'h300;
        @(negedge clk);
        chk("rst_gnt", 140'(if_gnt), 140'(1));
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_busy", 140'({mem_req, mem_addr}), 140'({1'b1, 32'h300}));
        #1;
        reset = 1'b0;
        #1;
        chk("rst_async", 140'({mem_req, mem_addr, mem_be, if_gnt, ls_gnt, stall_if,
            stall_mem, if_rvalid, ls_rvalid, if_rdata, ls_rdata}), 140'(0));
        @(posedge clk);
        #1;
        mem_ready = 1'b1; mem_rdata = 32'h99;
        @(posedge clk);
        #1;
        reset = 1'b1; if_req = 1'b0; mem_ready = 1'b0;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (if_rvalid || mem_req) seen = 1'b1;
        end
        chk("rst_no_rvalid", 140'(seen), 140'(0));
        chk("rst_rdata", 140'({if_rdata, ls_rdata}), 140'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 4, SHALL be the number of consecutive load/store grants allowed while a fetch is pending.
REQ-002 Port clk  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-003 Port reset  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 Ports if_req in 1, if_addr in 32 SHALL carry the fetch request (read only).
REQ-005 Ports if_gnt out 1, if_rvalid out 1, if_rdata out 32 SHALL carry fetch grant, completion pulse and read data.
REQ-006 Ports ls_req in 1, ls_we in 1, ls_be in 4, ls_addr in 32, ls_wdata in 32 SHALL carry the load/store request.
REQ-007 Ports ls_gnt out 1, ls_rvalid out 1, ls_rdata out 32 SHALL carry load/store grant, completion pulse and load data.
REQ-008 Ports mem_req out 1, mem_we out 1, mem_be out 4, mem_addr out 32, mem_wdata out 32 SHALL drive the single shared memory port.
REQ-009 Ports mem_rdata in 32, mem_ready in 1 SHALL be memory read data and access-complete strobe.
REQ-010 Ports stall_if out 1, stall_mem out 1 SHALL be pipeline stall requests for the IF and MEM stages.

Function
REQ-011 States SHALL be IDLE, BUSY_IF, BUSY_LS.
REQ-012 In IDLE with no rvalid asserted this cycle, arbiter SHALL grant one pending requester: if_gnt or ls_gnt high for exactly that cycle (combinational from req and state).
REQ-013 Priority SHALL be load/store over fetch, except when starve_cnt == STARVE_MAX and if_req=1, then fetch SHALL win.
REQ-014 starve_cnt SHALL increment on each ls grant while if_req=1, clear on if grant or whenever if_req=0, saturate at STARVE_MAX.
REQ-015 On grant, request fields SHALL be latched; next state BUSY_IF or BUSY_LS.
REQ-016 In BUSY_x, mem_req=1 with latched addr/we/be/wdata held stable; fetch SHALL drive mem_we=0, mem_be=4'hF, mem_wdata=0.
REQ-017 When mem_ready=1 in BUSY_x, mem_rdata SHALL be registered and next state SHALL be IDLE.
REQ-018 Cycle after mem_ready, owner's rvalid SHALL pulse high one cycle with registered rdata; stores SHALL also pulse ls_rvalid (ack), ls_rdata=0.
REQ-019 No grant SHALL issue in a cycle where if_rvalid or ls_rvalid is high; minimum grant-to-grant spacing 3 cycles.
REQ-020 Minimum latency SHALL be: grant cycle T, mem_req T+1, rvalid T+2 when mem_ready=1 at T+1.
REQ-021 mem_ready while IDLE SHALL be ignored; mem_req SHALL be 0 in IDLE.
REQ-022 stall_if SHALL equal if_req & ~if_rvalid; stall_mem SHALL equal ls_req & ~ls_rvalid.
REQ-023 Requesters hold req and fields stable until their rvalid; request dropped before grant SHALL be treated as withdrawn, dropped after grant SHALL still complete.
REQ-024 Simultaneous if_req and ls_req in IDLE SHALL grant exactly one; both grants never high together.

Reset
REQ-025 reset low SHALL immediately force IDLE, starve_cnt=0, all outputs 0 (including mem_req mid-access), rdata registers 0.
REQ-026 Access in flight at reset SHALL be abandoned with no rvalid after reset release.

Verification
REQ-027 if_req only, if_addr=0x10, mem_ready=1 first BUSY cycle, mem_rdata=0x12345037 -> if_gnt T, mem_addr=0x10 T+1, if_rvalid with 0x12345037 at T+2, stall_if low at T+2.
REQ-028 Both req same cycle, ls_we=1, ls_addr=0x100, ls_wdata=0x123457FF, ls_be=4'hF -> ls_gnt first, mem_we=1, ls_rvalid then fetch granted 1 cycle later.
REQ-029 ls_req held continuously with if_req -> exactly 4 ls grants, then if_gnt, starve_cnt back to 0.
REQ-030 mem_ready held 0 for 5 cycles in BUSY_LS -> mem_* fields stable, stall_mem high throughout, ls_rvalid one cycle after ready.
REQ-031 reset pulled low during BUSY_IF with mem_req=1 -> mem_req 0 immediately, state IDLE, no if_rvalid after release.
REQ-032 Byte load ls_be=4'b0010, ls_addr=0x101, mem_rdata=0xFFFF58FF -> mem_be=4'b0010 passed through, ls_rdata=0xFFFF58FF unmodified.
